// File: rtl/gpr_scoreboard_file.sv
// 2-read/1-write register file with per-entry pending (busy) bits and optional hardwired zero entry.
// Optional same-cycle write-to-read bypass is enabled by defining GPR_SCOREBOARD_BYPASS_EN.
module gpr_scoreboard_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata2,
  input  logic                  busy_set,
  input  logic [ADDR_WIDTH-1:0] busy_addr,
  output logic                  busy1,
  output logic                  busy2
);
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf   [NREG];
  logic [NREG-1:0]       busy;

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign rf[i]   = '0;
      assign busy[i] = 1'b0;
    end else begin : g_entry
      logic [DATA_WIDTH-1:0] q;
      logic                  b;
      logic                  hit_w, hit_s;
      assign hit_w = wen && (waddr == ADDR_WIDTH'(i));
      assign hit_s = busy_set && (busy_addr == ADDR_WIDTH'(i));
      // set has priority over clear: a newer producer is still outstanding
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
          b <= 1'b0;
        end else begin
          if (hit_w) q <= wdata;
          if (hit_s)      b <= 1'b1;
          else if (hit_w) b <= 1'b0;
        end
      end
      assign rf[i]   = q;
      assign busy[i] = b;
    end
  end

`ifdef GPR_SCOREBOARD_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wen && (waddr == raddr1) && !(ZERO_REG != 0 && raddr1 == '0);
  assign byp2 = wen && (waddr == raddr2) && !(ZERO_REG != 0 && raddr2 == '0);

  always_comb begin
    rdata1 = rf[raddr1];
    busy1  = busy[raddr1];
    rdata2 = rf[raddr2];
    busy2  = busy[raddr2];
    if (byp1) begin
      rdata1 = wdata;
      busy1  = busy_set && (busy_addr == raddr1);
    end
    if (byp2) begin
      rdata2 = wdata;
      busy2  = busy_set && (busy_addr == raddr2);
    end
  end
`else
  assign rdata1 = rf[raddr1];
  assign busy1  = busy[raddr1];
  assign rdata2 = rf[raddr2];
  assign busy2  = busy[raddr2];
`endif

endmodule
